m_store_buffer: RTL and testbench

Parametrised M-stage store unit that replaces the purely combinational byte-enable path. It computes lane-aligned write data and byte enables for word, half, byte and (64-bit builds) double stores, and flags misaligned stores. Accepted stores are queued in a DEPTH-entry FIFO with tail write-combining, then drained to the data-memory bus over a valid/ready handshake. It stalls the M stage when the buffer is full or when a load overlaps a pending store.

---
 rtl/m_store_buffer_pkg.sv | 14 +
 rtl/m_st_align.sv | 39 +++
 rtl/m_store_buffer.sv | 124 ++++++++++++
 tb/tb_m_store_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m_store_buffer_pkg.sv
// Shared store-type encodings and address helpers for the M-stage store path.
package m_store_buffer_pkg;

  localparam logic [1:0] type_w = 2'b00;
  localparam logic [1:0] type_h = 2'b01;
  localparam logic [1:0] type_b = 2'b10;
  localparam logic [1:0] type_d = 2'b11;

  // Clear the in-word byte offset bits of a byte address.
  function automatic logic [31:0] word_align(input logic [31:0] a, input int unsigned off_w);
    return a & ~((32'(1) << off_w) - 32'(1));
  endfunction

endpackage

// File: rtl/m_st_align.sv
// Store lane alignment: byte enables, lane-shifted data and misalignment flag.
module m_st_align
  import m_store_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W  = DATA_W / 8,
  localparam int unsigned OFF_W = $clog2(BE_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        typ,
  input  logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   byteen,
  output logic [DATA_W-1:0] lanedata,
  output logic              misalign
);

  // Decode enables and alignment legality from the store size and offset.
  always_comb begin
    byteen   = '0;
    misalign = 1'b0;
    lanedata = wdata << {off, 3'b000};
    case (typ)
      type_b: byteen = BE_W'(1) << off;
      type_h: begin
        byteen   = BE_W'(2'b11) << off;
        misalign = off[0];
      end
      type_w: begin
        byteen   = BE_W'(4'hF) << off;
        misalign = (off[1:0] != 2'b00);
      end
      default: begin
        byteen   = '1;
        misalign = (DATA_W == 32) || (off != '0);
      end
    endcase
  end

endmodule

// File: rtl/m_store_buffer.sv
// M-stage store buffer: aligned stores queued with tail write-combining, drained over valid/ready.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned BE_W  = DATA_W / 8,
  localparam int unsigned OFF_W = $clog2(BE_W),
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [31:0]       Addr,
  input  logic [1:0]        Type,
  input  logic [DATA_W-1:0] WData,
  input  logic              Req,
  input  logic              LdEn,
  input  logic [31:0]       LdAddr,
  output logic              Stall,
  output logic              AdES,
  output logic              BusValid,
  input  logic              BusReady,
  output logic [31:0]       BusAddr,
  output logic [DATA_W-1:0] BusWData,
  output logic [BE_W-1:0]   BusByteEn,
  output logic              Empty,
  output logic [CNT_W-1:0]  Count
);

  logic [31:0]       addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, tail_last;
  logic [CNT_W-1:0]  count_q;

  logic [BE_W-1:0]   st_be;
  logic [DATA_W-1:0] st_data, merged_data;
  logic              st_mis, live, full, merge_hit, ld_hit;
  logic              push, merge_en, pop;
  logic [31:0]       st_waddr, ld_waddr;
  logic [PTR_W-1:0]  rel;

  m_st_align #(.DATA_W(DATA_W)) u_align (
    .off      (Addr[OFF_W-1:0]),
    .typ      (Type),
    .wdata    (WData),
    .byteen   (st_be),
    .lanedata (st_data),
    .misalign (st_mis)
  );

  assign st_waddr  = word_align(Addr, OFF_W);
  assign ld_waddr  = word_align(LdAddr, OFF_W);
  assign tail_last = tail_q - PTR_W'(1);
  assign AdES      = WE & st_mis;
  assign live      = WE & ~Req & ~st_mis;
  assign full      = (count_q == CNT_W'(DEPTH));
  // The head may already be on the bus, so only a non-head tail (Count>=2) can absorb a store.
  assign merge_hit = live & (count_q >= CNT_W'(2)) & (addr_q[tail_last] == st_waddr);

  // Load overlap against every occupied entry's word address.
  always_comb begin
    ld_hit = 1'b0;
    rel    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rel = PTR_W'(i) - head_q;
      if (({1'b0, rel} < count_q) && (addr_q[i] == ld_waddr)) ld_hit = 1'b1;
    end
  end

  // Byte-wise merge of the new store lanes into the tail entry.
  always_comb begin
    merged_data = data_q[tail_last];
    for (int b = 0; b < int'(BE_W); b++) begin
      if (st_be[b]) merged_data[8*b +: 8] = st_data[8*b +: 8];
    end
  end

  // Full stall ignores a same-cycle pop; a killed store never stalls.
  assign Stall     = (live & ~merge_hit & full) | (LdEn & ld_hit);
  assign push      = live & ~merge_hit & ~Stall;
  assign merge_en  = merge_hit & ~Stall;
  assign Empty     = (count_q == '0);
  assign BusValid  = ~Empty;
  assign pop       = BusValid & BusReady;
  assign Count     = count_q;
  assign BusAddr   = BusValid ? addr_q[head_q] : '0;
  assign BusWData  = BusValid ? data_q[head_q] : '0;
  assign BusByteEn = BusValid ? be_q[head_q]   : '0;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= st_waddr;
        data_q[tail_q] <= st_data;
        be_q[tail_q]   <= st_be;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (merge_en) begin
        data_q[tail_last] <= merged_data;
        be_q[tail_last]   <= be_q[tail_last] | st_be;
      end
      if (pop) head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer (DATA_W=32, DEPTH=4) with a queue-based reference model.
module tb_m_store_buffer;
  import m_store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE, Req, LdEn, BusReady;
  logic [31:0] Addr, LdAddr, WData;
  logic [1:0]  Type;
  logic        Stall, AdES, BusValid, Empty;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusByteEn;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  typedef struct {
    logic        ades;
    logic        stall;
    logic        push;
    logic        merge;
    logic [31:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } eval_t;

  entry_t mq[$];

  m_store_buffer #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .WE(WE), .Addr(Addr), .Type(Type), .WData(WData),
    .Req(Req), .LdEn(LdEn), .LdAddr(LdAddr), .Stall(Stall), .AdES(AdES),
    .BusValid(BusValid), .BusReady(BusReady), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusByteEn(BusByteEn), .Empty(Empty), .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the buffer must do with the presented inputs given the queued entries.
  function automatic eval_t model_eval();
    eval_t      e;
    logic [1:0] off;
    logic       bad, live, ld;
    off     = Addr[1:0];
    e.waddr = Addr & ~32'h3;
    e.data  = WData << (8 * off);
    case (Type)
      type_b:  begin e.be = 4'b0001 << off; bad = 1'b0; end
      type_h:  begin e.be = 4'b0011 << off; bad = off[0]; end
      type_w:  begin e.be = 4'hF; bad = (off != 2'b00); end
      default: begin e.be = 4'hF; bad = 1'b1; end
    endcase
    e.ades = WE & bad;
    live   = WE & ~Req & ~bad;
    e.merge = live && (mq.size() >= 2) && (mq[mq.size()-1].addr == e.waddr);
    ld = 1'b0;
    foreach (mq[i]) if (mq[i].addr == (LdAddr & ~32'h3)) ld = 1'b1;
    e.stall = (live && !e.merge && mq.size() == 4) || (LdEn && ld);
    e.push  = live && !e.merge && !e.stall;
    e.merge = e.merge && !e.stall;
    return e;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Reference model state update on each active edge or async reset.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
    end else begin
      eval_t  e;
      entry_t t;
      logic   do_pop;
      int     last;
      e      = model_eval();
      do_pop = (mq.size() > 0) && BusReady;
      if (e.merge) begin
        last = mq.size() - 1;
        t    = mq[last];
        for (int b = 0; b < 4; b++) if (e.be[b]) t.data[8*b +: 8] = e.data[8*b +: 8];
        t.be = t.be | e.be;
        mq[last] = t;
      end
      if (e.push) begin
        t.addr = e.waddr; t.data = e.data; t.be = e.be;
        mq.push_back(t);
      end
      if (do_pop) void'(mq.pop_front());
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the active edge.
  initial forever begin
    eval_t e;
    @(negedge clk);
    e = model_eval();
    check("stall", Stall, e.stall);
    check("ades", AdES, e.ades);
    check("count", Count, mq.size());
    check("empty", Empty, mq.size() == 0);
    check("busvalid", BusValid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("busaddr", BusAddr, mq[0].addr);
      check("busbyteen", BusByteEn, mq[0].be);
      check("buswdata", BusWData & lane_mask(mq[0].be), mq[0].data & lane_mask(mq[0].be));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    WE = 1'b1; Addr = a; Type = t; WData = d;
  endtask

  task automatic idle();
    WE = 1'b0; Req = 1'b0; Addr = '0; Type = type_w; WData = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; idle(); LdEn = 1'b0; LdAddr = '0; BusReady = 1'b0;
    @(negedge clk);
    check("rst_count", Count, 3'd0);
    check("rst_empty", Empty, 1'b1);
    check("rst_busvalid", BusValid, 1'b0);
    check("rst_busaddr", BusAddr, 32'h0);
    check("rst_buswdata", BusWData, 32'h0);
    check("rst_busbyteen", BusByteEn, 4'h0);
    tick(); reset = 1'b0;

    // alignment of a byte store to the top lane
    BusReady = 1'b1; st(32'h1003, type_b, 32'hAB); tick(); idle();
    @(negedge clk);
    check("align_be", BusByteEn, 4'b1000);
    check("align_lane", BusWData[31:24], 8'hAB);
    check("align_addr", BusAddr, 32'h1000);
    tick();
    @(negedge clk); check("align_drained", Empty, 1'b1);

    // misaligned half and illegal double
    st(32'h1001, type_h, 32'h1234);
    @(negedge clk); check("mis_h_ades", AdES, 1'b1);
    tick(); idle();
    @(negedge clk); check("mis_h_count", Count, 3'd0); check("mis_h_valid", BusValid, 1'b0);
    st(32'h1000, type_d, 32'h5678);
    @(negedge clk); check("mis_d_ades", AdES, 1'b1);
    tick(); idle();
    @(negedge clk); check("mis_d_count", Count, 3'd0);

    // tail write-combining
    BusReady = 1'b0;
    st(32'h2000, type_w, 32'h11223344); tick();
    st(32'h3000, type_b, 32'h55); tick();
    st(32'h3001, type_b, 32'h66); tick(); idle();
    @(negedge clk); check("merge_count", Count, 3'd2);
    BusReady = 1'b1; tick();
    @(negedge clk);
    check("merge_addr", BusAddr, 32'h3000);
    check("merge_be", BusByteEn, 4'b0011);
    check("merge_data", BusWData[15:0], 16'h6655);
    tick();
    @(negedge clk); check("merge_drained", Empty, 1'b1);

    // the sole (head) entry never absorbs a store
    BusReady = 1'b0;
    st(32'h8000, type_w, 32'hA5A5A5A5); tick();
    st(32'h8001, type_b, 32'h77); tick(); idle();
    @(negedge clk); check("head_nomerge_count", Count, 3'd2);
    BusReady = 1'b1; tick(); tick();

    // full, conservative stall, drain
    BusReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(32'h5000 + 32'(4*i), type_w, 32'h100 + 32'(i)); tick();
    end
    st(32'h6000, type_w, 32'hCAFE);
    @(negedge clk); check("full_count", Count, 3'd4); check("full_stall", Stall, 1'b1);
    tick(); BusReady = 1'b1;
    @(negedge clk); check("full_stall_popcycle", Stall, 1'b1);
    tick();
    @(negedge clk); check("drain_count3", Count, 3'd3); check("drain_stall_low", Stall, 1'b0);
    tick(); idle();
    @(negedge clk); check("drain_pushpop", Count, 3'd3);
    repeat (3) tick();
    @(negedge clk); check("drain_empty", Empty, 1'b1);

    // load overlap hazard
    BusReady = 1'b0;
    st(32'h4000, type_w, 32'hDEADBEEF); tick(); idle();
    LdEn = 1'b1; LdAddr = 32'h4002;
    @(negedge clk); check("ld_hit_stall", Stall, 1'b1);
    tick(); LdAddr = 32'h4004;
    @(negedge clk); check("ld_miss_stall", Stall, 1'b0);
    tick(); LdAddr = 32'h4002; BusReady = 1'b1;
    @(negedge clk); check("ld_hit_before_pop", Stall, 1'b1);
    tick();
    @(negedge clk); check("ld_after_pop", Stall, 1'b0); check("ld_after_pop_empty", Empty, 1'b1);
    LdEn = 1'b0; LdAddr = '0;

    // flushed store is dropped
    BusReady = 1'b0;
    st(32'h7000, type_w, 32'h1); Req = 1'b1;
    @(negedge clk); check("flush_nostall", Stall, 1'b0);
    tick(); idle();
    @(negedge clk); check("flush_count", Count, 3'd0);

    // asynchronous reset with pending entries
    for (int i = 0; i < 3; i++) begin
      st(32'h9000 + 32'(4*i), type_w, 32'h900 + 32'(i)); tick();
    end
    idle();
    @(negedge clk); check("prereset_count", Count, 3'd3);
    #1 reset = 1'b1;
    #1;
    check("async_count", Count, 3'd0);
    check("async_busvalid", BusValid, 1'b0);
    check("async_empty", Empty, 1'b1);
    tick(); reset = 1'b0;
    @(negedge clk); check("post_reset_count", Count, 3'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
